jserial_alu: RTL and testbench

Bit-serial arithmetic/compare unit that reuses one full-adder cell and one comparator cell over 8 clock cycles instead of eight parallel copies. It accepts two bytes on a start strobe and streams them through the cell, LSB-first for addition and MSB-first for comparison. It returns a byte result plus carry, equal, a-larger and zero flags, with a busy/done handshake. It sits beside the byte-parallel ALU as the low-gate-count sequential alternative for the CPU datapath.

---
 rtl/jserial_alu.sv | 153 +++++++++++++++
 tb/tb_jserial_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jserial_alu.sv
// jserial_alu: bit-serial add / unsigned-compare unit.
//
// One full-adder cell and one comparator cell are reused over WIDTH clock
// cycles. Operands are latched on an accepted start. Addition walks the bits
// LSB-first and compare walks them MSB-first. Results and flags are
// registered and are presented with a single-cycle done pulse.
//
// Ports:
//   wclk      in   1      clock, rising edge
//   wreset    in   1      synchronous, active-high reset
//   wstart    in   1      start request (accepted in IDLE, or on the DONE exit edge)
//   wop       in   1      0 = add, 1 = compare
//   wa, wb    in   WIDTH  operands
//   wci       in   1      carry-in for add
//   wsum      out  WIDTH  add: A+B+ci mod 2^WIDTH; compare: A xor B
//   wco       out  1      add carry-out (0 for compare)
//   weq       out  1      compare A == B (0 for add)
//   walarger  out  1      compare A > B unsigned (0 for add)
//   wzero     out  1      wsum == 0
//   wbusy     out  1      high while bits are being processed
//   wdone     out  1      single-cycle pulse, results valid
module jserial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             wclk,
    input  logic             wreset,
    input  logic             wstart,
    input  logic             wop,
    input  logic [WIDTH-1:0] wa,
    input  logic [WIDTH-1:0] wb,
    input  logic             wci,
    output logic [WIDTH-1:0] wsum,
    output logic             wco,
    output logic             weq,
    output logic             walarger,
    output logic             wzero,
    output logic             wbusy,
    output logic             wdone
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             c_q;
    logic             eq_q;
    logic             al_q;
    logic [CW-1:0]    cnt;

    // Single-bit cell inputs and next-state values for the current bit.
    logic [CW-1:0]    idx;
    logic             abit;
    logic             bbit;
    logic [WIDTH-1:0] sum_nx;
    logic             c_nx;
    logic             eq_nx;
    logic             al_nx;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sum_nx = wsum;
        c_nx   = c_q;
        eq_nx  = eq_q;
        al_nx  = al_q;
        // Compare walks from the MSB down; add walks from the LSB up.
        idx    = op_q ? (LAST - cnt) : cnt;
        abit   = a_q[idx];
        bbit   = b_q[idx];
        if (op_q) begin
            sum_nx[idx] = abit ^ bbit;
            // A is larger at the first differing bit (from the top) where A has the 1.
            al_nx       = al_q | (eq_q & abit & ~bbit);
            eq_nx       = eq_q & ~(abit ^ bbit);
        end else begin
            sum_nx[idx] = abit ^ bbit ^ c_q;
            c_nx        = (abit & bbit) | (c_q & (abit ^ bbit));
        end
    end

    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wreset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            c_q      <= 1'b0;
            eq_q     <= 1'b0;
            al_q     <= 1'b0;
            cnt      <= '0;
            wsum     <= '0;
            wco      <= 1'b0;
            weq      <= 1'b0;
            walarger <= 1'b0;
            wzero    <= 1'b0;
            wbusy    <= 1'b0;
            wdone    <= 1'b0;
        end else begin
            case (state)
                // The DONE exit edge also samples wstart, which gives back-to-back
                // operations one start every WIDTH+1 cycles.
                IDLE, DONE: begin
                    wdone <= 1'b0;
                    if (wstart) begin
                        state    <= RUN;
                        wbusy    <= 1'b1;
                        a_q      <= wa;
                        b_q      <= wb;
                        op_q     <= wop;
                        c_q      <= wop ? 1'b0 : wci;
                        eq_q     <= 1'b1;
                        al_q     <= 1'b0;
                        cnt      <= '0;
                        wsum     <= '0;
                        wco      <= 1'b0;
                        weq      <= 1'b0;
                        walarger <= 1'b0;
                        wzero    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    wsum <= sum_nx;
                    c_q  <= c_nx;
                    eq_q <= eq_nx;
                    al_q <= al_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        wbusy    <= 1'b0;
                        wdone    <= 1'b1;
                        wco      <= ~op_q & c_nx;
                        weq      <= op_q & eq_nx;
                        walarger <= op_q & al_nx;
                        wzero    <= (sum_nx == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jserial_alu.sv
module tb_jserial_alu;

    localparam int WIDTH = 8;

    logic             clk;
    logic             wreset;
    logic             wstart;
    logic             wop;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic             wci;
    logic [WIDTH-1:0] wsum;
    logic             wco;
    logic             weq;
    logic             walarger;
    logic             wzero;
    logic             wbusy;
    logic             wdone;

    jserial_alu #(.WIDTH(WIDTH)) dut (
        .wclk     (clk),
        .wreset   (wreset),
        .wstart   (wstart),
        .wop      (wop),
        .wa       (wa),
        .wb       (wb),
        .wci      (wci),
        .wsum     (wsum),
        .wco      (wco),
        .weq      (weq),
        .walarger (walarger),
        .wzero    (wzero),
        .wbusy    (wbusy),
        .wdone    (wdone)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             eq;
        logic             al;
        logic             zero;
        int               start;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: plain integer arithmetic on the latched operands.
    function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic ci, input int start);
        exp_t        e;
        int unsigned total;
        if (op) begin
            e.sum = a ^ b;
            e.co  = 1'b0;
            e.eq  = (a == b);
            e.al  = (a > b);
        end else begin
            total = int'(a) + int'(b) + int'(ci);
            e.sum = total[WIDTH-1:0];
            e.co  = total[WIDTH];
            e.eq  = 1'b0;
            e.al  = 1'b0;
        end
        e.zero  = (e.sum == '0);
        e.start = start;
        return e;
    endfunction

    // Called in the active region right after an accepting edge; edge_cnt
    // still holds the previous count there.
    task automatic push(input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic ci);
        q.push_back(model(op, a, b, ci, edge_cnt + 1));
    endtask

    task automatic scramble();
        wa  = WIDTH'($urandom);
        wb  = WIDTH'($urandom);
        wop = 1'($urandom);
        wci = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 4 * WIDTH && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_op(input logic op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ci);
        @(negedge clk);
        wstart = 1'b1; wop = op; wa = a; wb = b; wci = ci;
        @(posedge clk);
        push(op, a, b, ci);
        @(negedge clk);
        wstart = 1'b0;
        scramble();
        wait_idle();
    endtask

    // wstart held high: each accepted start must follow the previous one by WIDTH+1 edges.
    task automatic run_held(input int n);
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
            wstart = 1'b1; wop = op; wa = a; wb = b; wci = ci;
            @(posedge clk);
            push(op, a, b, ci);
            repeat (WIDTH) @(posedge clk);
        end
        @(negedge clk);
        wstart = 1'b0;
        wait_idle();
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic exp_busy;
        logic exp_done;
        forever begin
            @(posedge clk);
            #1;
            if (wreset)
                check("reset_outputs", {wsum, wco, weq, walarger, wzero, wbusy, wdone}, 0);
            exp_busy = (q.size() != 0) && (edge_cnt >= q[0].start) &&
                       (edge_cnt <= q[0].start + WIDTH - 1);
            exp_done = (q.size() != 0) && (edge_cnt == q[0].start + WIDTH);
            check("busy", wbusy, exp_busy);
            check("done", wdone, exp_done);
            if (exp_done) begin
                e = q.pop_front();
                check("sum", wsum, e.sum);
                check("co", wco, e.co);
                check("eq", weq, e.eq);
                check("alarger", walarger, e.al);
                check("zero", wzero, e.zero);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two edges with start asserted and random operands.
        wreset = 1'b1;
        wstart = 1'b1;
        scramble();
        repeat (2) @(posedge clk);
        // Release with start still high: the first edge must accept it.
        @(negedge clk);
        wreset = 1'b0;
        wstart = 1'b1; wop = 1'b0; wa = 8'h5A; wb = 8'h3C; wci = 1'b0;
        @(posedge clk);
        push(1'b0, 8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        wstart = 1'b0;
        scramble();
        wait_idle();

        // Add with carry and compare corner cases.
        do_op(1'b0, 8'hFF, 8'h01, 1'b0);
        do_op(1'b0, 8'hFF, 8'h00, 1'b1);
        do_op(1'b0, 8'h10, 8'h20, 1'b1);
        do_op(1'b1, 8'h80, 8'h7F, 1'b0);
        do_op(1'b1, 8'h42, 8'h42, 1'b1);
        do_op(1'b1, 8'h01, 8'h02, 1'b0);

        // Start pulse during RUN cycle 3 must be ignored.
        @(negedge clk);
        wstart = 1'b1; wop = 1'b0; wa = 8'h01; wb = 8'h01; wci = 1'b0;
        @(posedge clk);
        push(1'b0, 8'h01, 8'h01, 1'b0);
        @(negedge clk);
        wstart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wstart = 1'b1; wa = 8'hFF; wop = 1'b1;
        @(negedge clk);
        wstart = 1'b0;
        wait_idle();

        // Back-to-back operations with start held high.
        run_held(3);

        // Reset in RUN cycle 4 of a compare: no done, then a clean add.
        @(negedge clk);
        wstart = 1'b1; wop = 1'b1; wa = WIDTH'($urandom); wb = WIDTH'($urandom); wci = 1'b0;
        @(posedge clk);
        push(1'b1, wa, wb, 1'b0);
        @(negedge clk);
        wstart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        wreset = 1'b1;
        q.delete();
        @(negedge clk);
        wreset = 1'b0;
        do_op(1'b0, 8'h7F, 8'h01, 1'b0);

        // Random operations.
        for (int i = 0; i < 24; i++)
            do_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

        repeat (4) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
